// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared fetch constants, state enum and buffer entry type
// Build option: IFETCH_BUF2_EN selects a 2-entry fetch buffer (default 1 entry).
package ifetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

`ifdef IFETCH_BUF2_EN
    localparam int BUF_DEPTH = 2;
`else
    localparam int BUF_DEPTH = 1;
`endif

endpackage

// File: rtl/ifetch_buf.sv
// rtl/ifetch_buf.sv - fetch buffer FIFO of {pc, instr} entries
// Ports: clk, rst (sync, active-high), flush (drops all entries), push/push_data,
// pop, full, empty, head (oldest entry; holds RESET_ENTRY until first write).
module ifetch_buf
    import ifetch_pkg::*;
#(
    parameter int           DEPTH       = 1,
    parameter fetch_entry_t RESET_ENTRY = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int SLOTS = 2 ** PW;

    fetch_entry_t      mem [SLOTS];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                mem[i] <= RESET_ENTRY;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch stage with fetch buffer and misaligned-redirect halt
// Build option: IFETCH_BUF2_EN (2-entry buffer, push gated only by buffer fullness).
// Ports: clk, rst (sync, active-high); imem_addr/imem_drdy/imem_rdata instruction memory;
// redirect_valid/redirect_pc redirect request; id_valid/id_ready/id_instr/id_pc decode
// handshake on the oldest buffered entry; fetch_fault sticky misaligned-redirect halt.
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic        imem_drdy,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        fetch_fault
);

    fetch_state_t state;
    fetch_state_t state_next;
    logic [31:0]  pc;
    logic [31:0]  pc_next;

    logic         push;
    logic         pop;
    logic         flush;
    logic         can_push;
    logic         buf_full;
    logic         buf_empty;
    fetch_entry_t buf_head;

    assign pop = !buf_empty && id_ready;

`ifdef IFETCH_BUF2_EN
    // Fullness alone gates the push, so id_ready never reaches pc or imem_addr.
    assign can_push = !buf_full;
`else
    // Single entry: a same-cycle pop frees the slot, keeping one instruction per cycle.
    assign can_push = !buf_full || pop;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        push       = 1'b0;
        flush      = 1'b0;
        case (state)
            RUN: begin
                if (redirect_valid) begin
                    flush = 1'b1;
                    if (redirect_pc[1:0] != 2'b00) begin
                        state_next = FAULT;
                    end else begin
                        pc_next = redirect_pc;
                    end
                end else if (imem_drdy && can_push) begin
                    push    = 1'b1;
                    pc_next = pc + 32'd4;
                end
            end
            FAULT: begin
                // Halted: buffer stays empty and redirects are ignored until reset.
            end
            default: state_next = FAULT;
        endcase
    end

    ifetch_buf #(
        .DEPTH       (BUF_DEPTH),
        .RESET_ENTRY ('{pc: RESET_PC, instr: NOP_INSTR})
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .push_data ('{pc: pc, instr: imem_rdata}),
        .pop       (pop),
        .full      (buf_full),
        .empty     (buf_empty),
        .head      (buf_head)
    );

    assign imem_addr   = {2'b00, pc[31:2]};
    assign id_valid    = !buf_empty;
    assign id_instr    = buf_head.instr;
    assign id_pc       = buf_head.pc;
    assign fetch_fault = (state == FAULT);

endmodule
